// File: rtl/mem_bus_arbiter.sv
// Two-requester arbiter for the single-ported data-memory bus (CPU and DMA).
// Fixed CPU priority with a starvation cap: after MAX_BURST consecutive CPU
// grants while DMA is pending, DMA is forced in. Accesses run IDLE -> ACCESS
// (-> WAIT for READ_LATENCY cycles on reads) -> IDLE with a one-cycle ack.
// Optional per-requester wait counters are built when MEM_ARB_STATS_EN is defined.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W       = 8,
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned READ_LATENCY = 0,
  parameter int unsigned MAX_BURST    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              owner
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [7:0]        cpu_wait_cnt,
  output logic [7:0]        dma_wait_cnt
`endif
);

  localparam logic [3:0] MaxBurst = 4'(MAX_BURST);
  localparam logic [1:0] RdLat    = 2'(READ_LATENCY);

  typedef enum logic [1:0] {StIdle, StAccess, StWait} state_e;

  state_e              state_q;
  logic                cmd_we_q;
  logic                owner_q;
  logic [3:0]          streak_q;
  logic [1:0]          wait_q;
  logic                cpu_ack_q, dma_ack_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W-1:0]   cpu_rdata_q, dma_rdata_q;

  logic                grant, dma_wins, win_we, rd_done;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  // Winner selection: DMA only when CPU is idle or the CPU streak hit the cap.
  always_comb begin
    grant     = cpu_req | dma_req;
    dma_wins  = dma_req & (~cpu_req | (streak_q == MaxBurst));
    win_we    = dma_wins ? dma_we    : cpu_we;
    win_addr  = dma_wins ? dma_addr  : cpu_addr;
    win_wdata = dma_wins ? dma_wdata : cpu_wdata;
    rd_done   = (cpu_ack_q | dma_ack_q) & ~cmd_we_q;
  end

  // Main FSM with registered acks, strobe and memory command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      cmd_we_q    <= 1'b0;
      owner_q     <= 1'b0;
      streak_q    <= 4'd0;
      wait_q      <= 2'd0;
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      mem_we_q  <= 1'b0;
      // Read data is live on mem_rdata during the ack cycle; keep a copy after.
      if (rd_done) begin
        if (owner_q) dma_rdata_q <= mem_rdata;
        else         cpu_rdata_q <= mem_rdata;
      end
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            owner_q     <= dma_wins;
            cmd_we_q    <= win_we;
            mem_addr_q  <= win_addr;
            mem_wdata_q <= win_wdata;
            mem_we_q    <= win_we;
            if (win_we || (RdLat == 2'd0)) begin
              cpu_ack_q <= ~dma_wins;
              dma_ack_q <= dma_wins;
            end
            if (dma_wins || !dma_req) streak_q <= 4'd0;
            else if (streak_q != MaxBurst) streak_q <= streak_q + 4'd1;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          if (cmd_we_q || (RdLat == 2'd0)) begin
            state_q <= StIdle;
          end else begin
            state_q <= StWait;
            wait_q  <= 2'd1;
            if (RdLat == 2'd1) begin
              cpu_ack_q <= ~owner_q;
              dma_ack_q <= owner_q;
            end
          end
        end
        StWait: begin
          if (wait_q == RdLat) begin
            state_q <= StIdle;
          end else begin
            wait_q <= wait_q + 2'd1;
            if ((wait_q + 2'd1) == RdLat) begin
              cpu_ack_q <= ~owner_q;
              dma_ack_q <= owner_q;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [7:0] cpu_wait_q, dma_wait_q;

  // Saturating counts of cycles spent requesting without an ack.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cpu_wait_q <= 8'd0;
      dma_wait_q <= 8'd0;
    end else begin
      if (cpu_req && !cpu_ack_q && (cpu_wait_q != 8'hFF)) cpu_wait_q <= cpu_wait_q + 8'd1;
      if (dma_req && !dma_ack_q && (dma_wait_q != 8'hFF)) dma_wait_q <= dma_wait_q + 8'd1;
    end
  end

  assign cpu_wait_cnt = cpu_wait_q;
  assign dma_wait_cnt = dma_wait_q;
`endif

  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign cpu_rdata = (cpu_ack_q && !cmd_we_q) ? mem_rdata : cpu_rdata_q;
  assign dma_rdata = (dma_ack_q && !cmd_we_q) ? mem_rdata : dma_rdata_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != StIdle);
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: one instance with READ_LATENCY=0 (table-driven
// single-requester transactions plus arbitration sequences) and one with
// READ_LATENCY=2 (delayed read and reset-during-WAIT). Wait-counter checks
// are compiled in when MEM_ARB_STATS_EN is defined.
module tb_mem_bus_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance 0 (READ_LATENCY=0)
  logic       c_req = 0, c_we = 0, d_req = 0, d_we = 0;
  logic [7:0] c_addr = 0, c_wdata = 0, d_addr = 0, d_wdata = 0;
  logic       cpu_ack0, dma_ack0, mem_we0, busy0, owner0;
  logic [7:0] cpu_rdata0, dma_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
  logic [7:0] mem0 [256];

  // Instance 2 (READ_LATENCY=2); CPU side idle
  logic       z_req = 0, z_we = 0, d2_req = 0, d2_we = 0;
  logic [7:0] z_addr = 0, z_wdata = 0, d2_addr = 0, d2_wdata = 0;
  logic       cpu_ack2, dma_ack2, mem_we2, busy2, owner2;
  logic [7:0] cpu_rdata2, dma_rdata2, mem_addr2, mem_wdata2, mem_rdata2;
  logic [7:0] mem2 [256];
  logic [7:0] a2_d1 = 0, a2_d2 = 0;

`ifdef MEM_ARB_STATS_EN
  logic [7:0] cpu_wait_cnt0, dma_wait_cnt0, cpu_wait_cnt2, dma_wait_cnt2;
`endif

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(0), .MAX_BURST(4)) u_dut0 (
    .clk(clk), .reset(rst_n),
    .cpu_req(c_req), .cpu_we(c_we), .cpu_addr(c_addr), .cpu_wdata(c_wdata),
    .cpu_ack(cpu_ack0), .cpu_rdata(cpu_rdata0),
    .dma_req(d_req), .dma_we(d_we), .dma_addr(d_addr), .dma_wdata(d_wdata),
    .dma_ack(dma_ack0), .dma_rdata(dma_rdata0),
    .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0), .mem_rdata(mem_rdata0),
    .busy(busy0), .owner(owner0)
`ifdef MEM_ARB_STATS_EN
    , .cpu_wait_cnt(cpu_wait_cnt0), .dma_wait_cnt(dma_wait_cnt0)
`endif
  );

  mem_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .READ_LATENCY(2), .MAX_BURST(4)) u_dut2 (
    .clk(clk), .reset(rst_n),
    .cpu_req(z_req), .cpu_we(z_we), .cpu_addr(z_addr), .cpu_wdata(z_wdata),
    .cpu_ack(cpu_ack2), .cpu_rdata(cpu_rdata2),
    .dma_req(d2_req), .dma_we(d2_we), .dma_addr(d2_addr), .dma_wdata(d2_wdata),
    .dma_ack(dma_ack2), .dma_rdata(dma_rdata2),
    .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rdata(mem_rdata2),
    .busy(busy2), .owner(owner2)
`ifdef MEM_ARB_STATS_EN
    , .cpu_wait_cnt(cpu_wait_cnt2), .dma_wait_cnt(dma_wait_cnt2)
`endif
  );

  // Zero-latency memory for instance 0
  assign mem_rdata0 = mem0[mem_addr0];
  always @(posedge clk) if (mem_we0) mem0[mem_addr0] <= mem_wdata0;

  // Two-cycle-latency read-only memory for instance 2
  always @(posedge clk) begin
    a2_d1 <= mem_addr2;
    a2_d2 <= a2_d1;
  end
  assign mem_rdata2 = mem2[a2_d2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       dma;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
  } vec_t;

  // Single-requester transaction on instance 0: ack must come 1 cycle after req.
  task automatic run_txn0(input int idx, input vec_t v);
    int  lat = 0;
    int  we_cnt = 0;
    int  other = 0;
    bit  got = 0;
    if (v.dma) begin d_req = 1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; end
    else       begin c_req = 1; c_we = v.we; c_addr = v.addr; c_wdata = v.wdata; end
    for (int i = 0; i < 8 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (mem_we0) we_cnt++;
      if (v.dma ? cpu_ack0 : dma_ack0) other++;
      if (v.dma ? dma_ack0 : cpu_ack0) begin
        got = 1;
        check($sformatf("v%0d_owner", idx), 32'(owner0), 32'(v.dma));
        if (!v.we)
          check($sformatf("v%0d_rdata", idx), 32'(v.dma ? dma_rdata0 : cpu_rdata0),
                32'(v.rdata));
        if (v.dma) d_req = 0; else c_req = 0;
      end
    end
    @(posedge clk); #1;
    if (mem_we0) we_cnt++;
    if (cpu_ack0 || dma_ack0) other++;
    check($sformatf("v%0d_ack_seen", idx), 32'(got), 32'd1);
    check($sformatf("v%0d_latency", idx), 32'(lat), 32'd1);
    check($sformatf("v%0d_mem_we_cycles", idx), 32'(we_cnt), 32'(v.we));
    check($sformatf("v%0d_stray_ack", idx), 32'(other), 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, both, cyc, cpu_at, dma_at, we_cnt, busy_cnt, ncpu;
    bit done;

    vecs[0] = '{dma: 0, we: 1, addr: 8'h10, wdata: 8'hA5, rdata: 8'h00};
    vecs[1] = '{dma: 0, we: 0, addr: 8'h10, wdata: 8'h00, rdata: 8'hA5};
    vecs[2] = '{dma: 1, we: 1, addr: 8'h20, wdata: 8'h3C, rdata: 8'h00};
    vecs[3] = '{dma: 1, we: 0, addr: 8'h20, wdata: 8'h00, rdata: 8'h3C};
    vecs[4] = '{dma: 0, we: 1, addr: 8'hFF, wdata: 8'h5A, rdata: 8'h00};
    vecs[5] = '{dma: 0, we: 0, addr: 8'hFF, wdata: 8'h00, rdata: 8'h5A};
    vecs[6] = '{dma: 1, we: 0, addr: 8'h10, wdata: 8'h00, rdata: 8'hA5};
    vecs[7] = '{dma: 0, we: 0, addr: 8'h20, wdata: 8'h00, rdata: 8'h3C};

    mem2[8'h00] = 8'h00;
    mem2[8'h20] = 8'h3C;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctrl0", 32'({cpu_ack0, dma_ack0, mem_we0, busy0, owner0}), 32'd0);
    check("reset_data0", {mem_addr0, mem_wdata0, cpu_rdata0, dma_rdata0}, 32'd0);
    check("reset_ctrl2", 32'({cpu_ack2, dma_ack2, mem_we2, busy2, owner2}), 32'd0);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;

    // Table-driven transactions
    for (int i = 0; i < 8; i++) run_txn0(i, vecs[i]);

    // Both requests held: CPU x4 then DMA, repeating
    c_req = 1; c_we = 1; c_addr = 8'h40; c_wdata = 8'h11;
    d_req = 1; d_we = 1; d_addr = 8'h41; d_wdata = 8'h22;
    n = 0; both = 0;
    for (int i = 0; i < 40 && n < 10; i++) begin
      @(posedge clk); #1;
      if (cpu_ack0 && dma_ack0) both++;
      if (cpu_ack0 || dma_ack0) begin
        check($sformatf("burst_grant%0d_is_dma", n), 32'(dma_ack0), 32'((n % 5) == 4));
        n++;
      end
    end
    c_req = 0; d_req = 0;
    @(posedge clk); #1;
    check("burst_grant_count", 32'(n), 32'd10);
    check("burst_two_acks", 32'(both), 32'd0);

    // Simultaneous requests with streak cleared: CPU first, DMA next grant
    c_req = 1; c_we = 0; c_addr = 8'h10;
    d_req = 1; d_we = 0; d_addr = 8'h41;
    cyc = 0; cpu_at = 0; dma_at = 0;
    for (int i = 0; i < 10 && (c_req || d_req); i++) begin
      @(posedge clk); #1;
      cyc++;
      if (cpu_ack0) begin cpu_at = cyc; check("simul_cpu_rdata", 32'(cpu_rdata0), 32'hA5); c_req = 0; end
      if (dma_ack0) begin dma_at = cyc; check("simul_dma_rdata", 32'(dma_rdata0), 32'h22); d_req = 0; end
    end
    @(posedge clk); #1;
    check("simul_cpu_ack_cycle", 32'(cpu_at), 32'd1);
    check("simul_dma_ack_cycle", 32'(dma_at), 32'd3);

    // READ_LATENCY=2 DMA read
    d2_req = 1; d2_we = 0; d2_addr = 8'h20;
    cyc = 0; dma_at = 0; we_cnt = 0; busy_cnt = 0;
    for (int i = 0; i < 10 && d2_req; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_we2) we_cnt++;
      if (busy2) busy_cnt++;
      if (dma_ack2) begin dma_at = cyc; check("rl2_rdata_at_ack", 32'(dma_rdata2), 32'h3C); d2_req = 0; end
    end
    @(posedge clk); #1;
    if (busy2) busy_cnt++;
    if (mem_we2) we_cnt++;
    check("rl2_ack_cycle", 32'(dma_at), 32'd3);
    check("rl2_mem_we", 32'(we_cnt), 32'd0);
    check("rl2_busy_cycles", 32'(busy_cnt), 32'd3);
    check("rl2_rdata_held", 32'(dma_rdata2), 32'h3C);

    // Reset during WAIT of a DMA read
    d2_req = 1; d2_we = 0; d2_addr = 8'h20;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rstwait_in_wait", 32'({busy2, dma_ack2}), 32'b10);
    rst_n = 0;
    d2_req = 0;
    #1;
    check("rstwait_ctrl", 32'({cpu_ack2, dma_ack2, mem_we2, busy2, owner2}), 32'd0);
    check("rstwait_data", {mem_addr2, mem_wdata2, cpu_rdata2, dma_rdata2}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (dma_ack2 || busy2) n++;
    end
    check("rstwait_no_ack_after", 32'(n), 32'd0);

`ifdef MEM_ARB_STATS_EN
    // DMA waits behind three CPU writes: counted 6 cycles at its ack
    c_req = 1; c_we = 1; c_addr = 8'h50; c_wdata = 8'h01;
    ncpu = 0; done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk); #1;
      if (cpu_ack0) begin
        ncpu++;
        if (ncpu == 1) begin d_req = 1; d_we = 0; d_addr = 8'h10; end
        if (ncpu == 3) c_req = 0;
      end
      if (dma_ack0) begin
        done = 1;
        check("stats_dma_wait_at_ack", 32'(dma_wait_cnt0), 32'd6);
        check("stats_cpu_wait_at_dma_ack", 32'(cpu_wait_cnt0), 32'd3);
        d_req = 0;
      end
    end
    check("stats_dma_acked", 32'(done), 32'd1);
    @(posedge clk); #1;

    // Long contention: both counters saturate
    c_req = 1; c_we = 1; d_req = 1; d_we = 1;
    both = 0;
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (cpu_ack0 && dma_ack0) both++;
    end
    check("stats_dma_sat", 32'(dma_wait_cnt0), 32'd255);
    check("stats_cpu_sat", 32'(cpu_wait_cnt0), 32'd255);
    check("stats_two_acks", 32'(both), 32'd0);
    c_req = 0; d_req = 0;
    @(posedge clk); #1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
